// File: rtl/uart_threshold_commander_if.sv
// rtl/uart_threshold_commander_if.sv - request, UART byte and response signals of the threshold commander
//
// Purpose: bundles the request handshake, the byte-level UART core connection and
//          the response strobe of uart_threshold_commander into one interface.
// Ports (signals):
//   cmd_valid/cmd_mode[2:0]/cmd_dir  request from panel/sequencer, cmd_ready back
//   tx_data[7:0]/tx_start/tx_idle    transmit side of the UART core
//   rx_data[7:0]/rx_valid            receive side of the UART core
//   resp_valid/resp_error/resp_value[15:0]  result of each accepted request
// Modports: master = the commander, slave = requester plus UART core.
interface uart_threshold_commander_if;
    logic        cmd_valid;
    logic [2:0]  cmd_mode;
    logic        cmd_dir;
    logic        cmd_ready;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_idle;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        resp_valid;
    logic        resp_error;
    logic [15:0] resp_value;

    modport master (
        input  cmd_valid, cmd_mode, cmd_dir, tx_idle, rx_data, rx_valid,
        output cmd_ready, tx_data, tx_start, resp_valid, resp_error, resp_value
    );

    modport slave (
        output cmd_valid, cmd_mode, cmd_dir, tx_idle, rx_data, rx_valid,
        input  cmd_ready, tx_data, tx_start, resp_valid, resp_error, resp_value
    );
endinterface

// File: rtl/uart_threshold_commander.sv
// rtl/uart_threshold_commander.sv - host-side initiator for the threshold-tuning UART protocol
//
// Purpose: turns a one-shot request (mode, inc/dec) into [mode char] + 'w'/'s',
//          checks each echo and collects the 1- or 2-byte value reply.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset
//   bus  uart_threshold_commander_if.master (request, UART tx/rx, response)
// Parameters:
//   TIMEOUT_CYCLES  cycles allowed in one SEND/WAIT state before abort (>=2)
//   TO_W            timeout counter width, must hold TIMEOUT_CYCLES-1
module uart_threshold_commander #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TO_W           = 20
) (
    input  logic                         clk,
    input  logic                         rst,
    uart_threshold_commander_if.master   bus
);

    localparam logic [2:0] S_IDLE           = 3'd0;
    localparam logic [2:0] S_SEND_MODE      = 3'd1;
    localparam logic [2:0] S_WAIT_MODE_ECHO = 3'd2;
    localparam logic [2:0] S_SEND_DIR       = 3'd3;
    localparam logic [2:0] S_WAIT_DIR_ECHO  = 3'd4;
    localparam logic [2:0] S_WAIT_VAL_LO    = 3'd5;
    localparam logic [2:0] S_WAIT_VAL_HI    = 3'd6;
    localparam logic [2:0] S_DONE           = 3'd7;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]      state;
    logic [2:0]      state_d;
    logic [TO_W-1:0] to_cnt;
    logic [2:0]      mode_q;
    logic            dir_q;
    logic [2:0]      cache_mode;
    logic            cache_valid;
    logic [7:0]      lo_q;
    logic [7:0]      tx_data_q;

    logic [7:0]      mode_char;
    logic [7:0]      dir_char;
    logic [7:0]      tx_char;
    logic            timed_state;
    logic            expire;
    logic            fin_err;
    logic [15:0]     fin_val;
    logic            cache_load;
    logic            lo_load;
    logic            accept;

    assign mode_char = 8'h41 + {5'd0, mode_q};
    assign dir_char  = dir_q ? 8'h77 : 8'h73;

    assign bus.cmd_ready = (state == S_IDLE);
    assign accept        = bus.cmd_valid && (state == S_IDLE);

    // Only SEND/WAIT states are supervised; IDLE and DONE never time out.
    assign timed_state = (state != S_IDLE) && (state != S_DONE);
    assign expire      = timed_state && (to_cnt == TO_LAST);

    // tx_start is issued combinationally in the SEND cycle so the first byte
    // can leave the cycle right after accept; tx_data follows the char being
    // sent and otherwise holds the last byte handed to the UART core.
    always_comb begin
        bus.tx_start = 1'b0;
        tx_char      = tx_data_q;
        if (state == S_SEND_MODE) begin
            bus.tx_start = bus.tx_idle;
            tx_char      = mode_char;
        end else if (state == S_SEND_DIR) begin
            bus.tx_start = bus.tx_idle;
            tx_char      = dir_char;
        end
        bus.tx_data = bus.tx_start ? tx_char : tx_data_q;
    end

    // Next state. A received byte is evaluated before the timeout so a byte
    // arriving in the expiry cycle still counts.
    always_comb begin
        state_d    = state;
        fin_err    = 1'b0;
        fin_val    = 16'd0;
        cache_load = 1'b0;
        lo_load    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_mode == 3'd7) begin
                        state_d = S_DONE;
                        fin_err = 1'b1;
                    end else if (cache_valid && (cache_mode == bus.cmd_mode)) begin
                        state_d = S_SEND_DIR;
                    end else begin
                        state_d = S_SEND_MODE;
                    end
                end
            end
            S_SEND_MODE: begin
                if (bus.tx_idle) begin
                    state_d = S_WAIT_MODE_ECHO;
                end else if (expire) begin
                    state_d = S_DONE;
                    fin_err = 1'b1;
                end
            end
            S_WAIT_MODE_ECHO: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == mode_char) begin
                        state_d    = S_SEND_DIR;
                        cache_load = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        fin_err = 1'b1;
                    end
                end else if (expire) begin
                    state_d = S_DONE;
                    fin_err = 1'b1;
                end
            end
            S_SEND_DIR: begin
                if (bus.tx_idle) begin
                    state_d = S_WAIT_DIR_ECHO;
                end else if (expire) begin
                    state_d = S_DONE;
                    fin_err = 1'b1;
                end
            end
            S_WAIT_DIR_ECHO: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == dir_char) begin
                        state_d = S_WAIT_VAL_LO;
                    end else begin
                        state_d = S_DONE;
                        fin_err = 1'b1;
                    end
                end else if (expire) begin
                    state_d = S_DONE;
                    fin_err = 1'b1;
                end
            end
            S_WAIT_VAL_LO: begin
                if (bus.rx_valid) begin
                    lo_load = 1'b1;
                    if (mode_q == 3'd0) begin
                        state_d = S_WAIT_VAL_HI;
                    end else begin
                        state_d = S_DONE;
                        fin_val = {{8{bus.rx_data[7]}}, bus.rx_data};
                    end
                end else if (expire) begin
                    state_d = S_DONE;
                    fin_err = 1'b1;
                end
            end
            S_WAIT_VAL_HI: begin
                if (bus.rx_valid) begin
                    state_d = S_DONE;
                    fin_val = {bus.rx_data, lo_q};
                end else if (expire) begin
                    state_d = S_DONE;
                    fin_err = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            to_cnt         <= '0;
            mode_q         <= 3'd0;
            dir_q          <= 1'b0;
            cache_mode     <= 3'd0;
            cache_valid    <= 1'b0;
            lo_q           <= 8'd0;
            tx_data_q      <= 8'd0;
            bus.resp_valid <= 1'b0;
            bus.resp_error <= 1'b0;
            bus.resp_value <= 16'd0;
        end else begin
            state <= state_d;

            // Counts cycles spent in the current state; any transition restarts it.
            if ((state_d != state) || !timed_state) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (accept) begin
                mode_q <= bus.cmd_mode;
                dir_q  <= bus.cmd_dir;
            end

            if (bus.tx_start) begin
                tx_data_q <= tx_char;
            end

            if (lo_load) begin
                lo_q <= bus.rx_data;
            end

            if (cache_load) begin
                cache_mode  <= mode_q;
                cache_valid <= 1'b1;
            end else if (fin_err) begin
                cache_valid <= 1'b0;
            end

            // Response strobe lives exactly for the DONE cycle; the value is
            // only rewritten on the way into DONE and holds otherwise.
            bus.resp_valid <= (state_d == S_DONE);
            bus.resp_error <= (state_d == S_DONE) && fin_err;
            if (state_d == S_DONE) begin
                bus.resp_value <= fin_err ? 16'd0 : fin_val;
            end
        end
    end

endmodule
